// File: rtl/a2d_intf.sv
// SPI master for the ADC: two 16-bit frames per conversion, frame 2 returns the 12-bit result.
// Optional build macro A2D_RES_INV_EN inverts the result (darker line reads larger).
`timescale 1ns/1ps
module a2d_intf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        a2d_SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned BIT_W = 5;
  localparam int unsigned GAP_W = 5;
  localparam int unsigned SR_W  = 16;
  localparam int unsigned RES_W = 12;

  localparam logic [CNT_W-1:0] CNT_LOAD     = 5'b10111;
  localparam logic [CNT_W-1:0] CNT_RISE     = 5'b01111;
  localparam logic [CNT_W-1:0] CNT_FALL     = 5'b11111;
  localparam logic [BIT_W-1:0] BITS_PER_FRM = 5'd16;
  localparam logic [GAP_W-1:0] GAP_LAST     = 5'd31;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FRM1 = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] FRM2 = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state, nxt_state;
  logic [CNT_W-1:0] sclk_cnt;
  logic [BIT_W-1:0] rise_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [SR_W-1:0]  shft_reg;
  logic [2:0]       chnl_q;
  logic [2:0]       chnl_src;
  logic [RES_W-1:0] res_nxt;
  logic             accept, in_frm, nxt_in_frm, frm_start, frm_end;
  logic             sclk_rise, sclk_fall, cnv_end;

  assign in_frm     = (state == FRM1) || (state == FRM2);
  assign nxt_in_frm = (nxt_state == FRM1) || (nxt_state == FRM2);
  assign sclk_rise  = in_frm && (sclk_cnt == CNT_RISE);
  assign sclk_fall  = in_frm && (sclk_cnt == CNT_FALL);
  // The 16th rising edge has already happened; leave the frame on this clk
  assign frm_end    = in_frm && (rise_cnt == BITS_PER_FRM);
  assign frm_start  = accept || ((state == GAP) && (nxt_state == FRM2));
  assign cnv_end    = (state == FRM2) && (nxt_state == DONE);
  assign chnl_src   = accept ? chnnl : chnl_q;

`ifdef A2D_RES_INV_EN
  assign res_nxt = ~shft_reg[RES_W-1:0];
`else
  assign res_nxt = shft_reg[RES_W-1:0];
`endif

  assign SCLK = sclk_cnt[CNT_W-1];
  assign MOSI = shft_reg[SR_W-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (strt_cnv) begin
              nxt_state = FRM1;
              accept    = 1'b1;
            end
      FRM1: if (frm_end) nxt_state = GAP;
      GAP:  if (gap_cnt == GAP_LAST) nxt_state = FRM2;
      FRM2: if (frm_end) nxt_state = DONE;
      DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // SPI datapath: divider, edge counter, gap timer, shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_cnt <= CNT_LOAD;
      rise_cnt <= '0;
      gap_cnt  <= '0;
      shft_reg <= '0;
      chnl_q   <= '0;
    end else begin
      if (in_frm && nxt_in_frm) sclk_cnt <= CNT_W'(sclk_cnt + 1'b1);
      else                      sclk_cnt <= CNT_LOAD;

      if (frm_start)      rise_cnt <= '0;
      else if (sclk_rise) rise_cnt <= BIT_W'(rise_cnt + 1'b1);

      if (state == GAP) gap_cnt <= GAP_W'(gap_cnt + 1'b1);
      else              gap_cnt <= '0;

      if (accept) chnl_q <= chnnl;

      // First falling edge of a frame only starts the clock, so no shift there
      if (frm_start)
        shft_reg <= {2'b00, chnl_src, 11'b0};
      else if (sclk_rise)
        shft_reg[0] <= MISO;
      else if (sclk_fall && (rise_cnt != '0))
        shft_reg <= {shft_reg[SR_W-2:0], 1'b0};
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnv_cmplt <= 1'b0;
      res       <= '0;
      a2d_SS_n  <= 1'b1;
    end else begin
      a2d_SS_n <= !nxt_in_frm;
      if (accept)       cnv_cmplt <= 1'b0;
      else if (cnv_end) cnv_cmplt <= 1'b1;
      if (cnv_end) res <= res_nxt;
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Self-checking bench for a2d_intf with a behavioural SPI ADC slave and frame monitor.
`timescale 1ns/1ps
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        MISO;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        a2d_SS_n;
  logic        SCLK;
  logic        MOSI;

  logic [11:0] adc_val;

  int n_cmp  = 0;
  int n_fail = 0;

  a2d_intf dut (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .MISO(MISO), .cnv_cmplt(cnv_cmplt), .res(res),
    .a2d_SS_n(a2d_SS_n), .SCLK(SCLK), .MOSI(MOSI)
  );

  always #5 clk = ~clk;

  // Monitor + ADC slave model: everything observed on the falling clk edge
  int          cyc = 0;
  logic        prev_ss = 1'b1, prev_sc = 1'b1, prev_cc = 1'b0;
  int          rises = 0, idx = 0, t_rise = 0, t_fall = 0;
  bit          have_fall = 1'b0;
  logic [15:0] mosi_w = '0, miso_w = '0;
  int          frm_cnt = 0;
  int          frm_rises [64];
  logic [15:0] frm_mosi  [64];
  int          sclk_edges = 0, sclk_bad = 0, n_cmplt = 0;
  time         t_cmplt = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_ss = 1'b1; prev_sc = 1'b1; prev_cc = 1'b0;
      rises = 0; MISO = 1'b0;
    end else begin
      if (SCLK !== prev_sc) sclk_edges++;
      if (prev_ss && !a2d_SS_n) begin
        rises = 0; idx = 0; mosi_w = '0; have_fall = 1'b0;
        miso_w = {4'h0, adc_val};
        MISO = miso_w[15];
      end
      if (!a2d_SS_n) begin
        if (!prev_sc && SCLK) begin
          if (!have_fall || (cyc - t_fall) != 16) sclk_bad++;
          rises++; t_rise = cyc;
          mosi_w = {mosi_w[14:0], MOSI};
        end
        if (prev_sc && !SCLK) begin
          if (rises > 0) begin
            if ((cyc - t_rise) != 16) sclk_bad++;
            if (idx < 15) idx++;
            MISO = miso_w[15-idx];
          end
          have_fall = 1'b1; t_fall = cyc;
        end
      end
      if (!prev_ss && a2d_SS_n) begin
        frm_rises[frm_cnt % 64] = rises;
        frm_mosi[frm_cnt % 64]  = mosi_w;
        frm_cnt++;
      end
      if (!prev_cc && cnv_cmplt) begin
        n_cmplt++; t_cmplt = $time;
      end
      prev_ss = a2d_SS_n; prev_sc = SCLK; prev_cc = cnv_cmplt;
    end
  end

  function automatic logic [11:0] model_res(input logic [11:0] v);
`ifdef A2D_RES_INV_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic do_conv(input string nm, input logic [2:0] ch, input logic [11:0] val,
                         input logic [11:0] exp_res, input bit busy_poke);
    int f0, c0, lat;
    logic [11:0] prev_res;
    logic [15:0] exp_mosi;
    time t0;
    bit done;
    f0 = frm_cnt; c0 = n_cmplt; prev_res = res; adc_val = val;
    exp_mosi = {2'b00, ch, 11'b0};
    strt_cnv = 1'b1; chnnl = ch; t0 = $time;
    tick();
    strt_cnv = 1'b0; chnnl = 3'($urandom);
    chk({nm, "_cmplt_clr"}, 32'(cnv_cmplt), 32'd0);
    chk({nm, "_res_hold"}, 32'(res), 32'(prev_res));
    if (busy_poke) begin
      repeat (300) tick();
      strt_cnv = 1'b1; chnnl = 3'd2;
      tick();
      strt_cnv = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      if (cnv_cmplt) begin done = 1'b1; break; end
      tick();
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    lat = int'((t_cmplt - t0) / 10);
    chk_rng({nm, "_latency"}, lat, 1030, 1110);
    chk({nm, "_res"}, 32'(res), 32'(exp_res));
    repeat (50) tick();
    chk({nm, "_frames"}, 32'(frm_cnt - f0), 32'd2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_f%0d_sclks", nm, k + 1), 32'(frm_rises[(f0 + k) % 64]), 32'd16);
      chk($sformatf("%s_f%0d_mosi", nm, k + 1), 32'(frm_mosi[(f0 + k) % 64]), 32'(exp_mosi));
    end
    chk({nm, "_n_cmplt"}, 32'(n_cmplt - c0), 32'd1);
    chk({nm, "_cmplt_hold"}, 32'(cnv_cmplt), 32'd1);
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] val;
    logic [11:0] exp_res;
  } vec_t;

  vec_t vec [8];

  initial begin
    int e0, f0, c0;
    logic [2:0]  rch;
    logic [11:0] rval;
    bit seen;

    for (int i = 0; i < 8; i++) begin
      vec[i].ch      = 3'(i);
      vec[i].val     = 12'(12'h100 * i + 12'h0FF);
      vec[i].exp_res = model_res(vec[i].val);
    end

    rst_n = 1'b0; strt_cnv = 1'b0; chnnl = 3'd0; adc_val = 12'h000;
    repeat (3) tick();
    chk("rst_ss_n", 32'(a2d_SS_n), 32'd1);
    chk("rst_sclk", 32'(SCLK), 32'd1);
    chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);

    rst_n = 1'b1;
    e0 = sclk_edges;
    repeat (200) tick();
    chk("idle_sclk_edges", 32'(sclk_edges - e0), 32'd0);
    chk("idle_ss_n", 32'(a2d_SS_n), 32'd1);
    chk("idle_cmplt", 32'(cnv_cmplt), 32'd0);

    do_conv("single", 3'd5, 12'hA5C, model_res(12'hA5C), 1'b0);
    do_conv("busy", 3'd5, 12'h3C6, model_res(12'h3C6), 1'b1);

    for (int i = 0; i < 8; i++)
      do_conv($sformatf("chan%0d", i), vec[i].ch, vec[i].val, vec[i].exp_res, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rch  = 3'($urandom_range(0, 7));
      rval = 12'($urandom);
      do_conv($sformatf("rand%0d", i), rch, rval, model_res(rval), 1'b0);
    end

    // Reset in the middle of frame 2
    f0 = frm_cnt; adc_val = 12'h9E1;
    strt_cnv = 1'b1; chnnl = 3'd6;
    tick();
    strt_cnv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if ((frm_cnt - f0) >= 1 && !a2d_SS_n) begin seen = 1'b1; break; end
      tick();
    end
    chk("midrst_frame2_seen", 32'(seen), 32'd1);
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ss_n", 32'(a2d_SS_n), 32'd1);
    chk("midrst_sclk", 32'(SCLK), 32'd1);
    chk("midrst_res", 32'(res), 32'd0);
    chk("midrst_cmplt", 32'(cnv_cmplt), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    c0 = n_cmplt;
    repeat (1200) tick();
    chk("midrst_no_cmplt", 32'(n_cmplt - c0), 32'd0);
    chk("midrst_cmplt_low", 32'(cnv_cmplt), 32'd0);
    chk("midrst_res_after", 32'(res), 32'd0);
    chk("midrst_idle_ss_n", 32'(a2d_SS_n), 32'd1);

    chk("sclk_timing_bad", 32'(sclk_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_intf.md
A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 clk  input  1  system clock; the only clock in the block; all flops use its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 strt_cnv  input  1  single-cycle request for a conversion; comes from motion_cntrl start_conv.
REQ-004 chnnl  input  3  ADC channel to convert; captured in the cycle strt_cnv is accepted.
REQ-005 cnv_cmplt  output  1  conversion done; stays high until the next accepted strt_cnv.
REQ-006 res  output  12  conversion result; stable whenever cnv_cmplt=1.
REQ-007 a2d_SS_n  output  1  SPI slave select to the ADC, active-low.
REQ-008 SCLK  output  1  SPI clock, clk/32; idles high.
REQ-009 MOSI  output  1  SPI data to the ADC.
REQ-010 MISO  input  1  SPI data from the ADC.

Function
REQ-011 States:
- IDLE -> FRM1 on strt_cnv.
- FRM1 -> GAP at the end of frame 1.
- GAP -> FRM2 after 32 clk.
- FRM2 -> DONE at the end of frame 2.
- DONE -> IDLE in one clk.
REQ-012 strt_cnv is accepted only in IDLE; strt_cnv in any other state is ignored and SHALL NOT disturb the transaction in progress.
REQ-013 On acceptance, in the same clk: cnv_cmplt clears, chnnl is latched, and the 16-bit shift register loads {2'b00, chnnl, 11'b0}.
REQ-014 a2d_SS_n is low throughout FRM1 and FRM2, and high in IDLE, GAP and DONE.
REQ-015 Clock divider:
- 5-bit counter, loaded with 5'b10111 at each frame start; SCLK = counter[4].
- The counter is held at load value outside frames, so SCLK stays high.
REQ-016 SPI edges:
- MISO is sampled into the shift register LSB on each SCLK rising edge (counter 01111 -> 10000).
- The register shifts left on each SCLK falling edge (counter 11111 -> 00000), except the first falling edge of a frame.
- MOSI = shift register MSB at all times.
REQ-017 A frame ends on its 16th SCLK rising edge; the state changes one clk later.
REQ-018 Frame 1 transmits the channel address; the data received in frame 1 is discarded.
REQ-019 Frame 2:
- MOSI transmits the same channel word again.
- On leaving FRM2, res = shift register bits [11:0] (transformed per REQ-024) and cnv_cmplt sets.
REQ-020 Latency from accepted strt_cnv to cnv_cmplt=1 is 1070 +/- 40 clk.
REQ-021 A strt_cnv asserted in the same clk that DONE returns to IDLE is not accepted; strt_cnv is accepted from the first clk in IDLE.
REQ-022 res holds its last value until the next completed conversion; it is not cleared by strt_cnv.

Reset
REQ-023 While rst_n=0, regardless of clk:
- state=IDLE; cnv_cmplt=0; res=12'h000; a2d_SS_n=1; SCLK=1; MOSI=0.
- Divider = 5'b10111; shift register = 0.
- Reset mid-frame aborts the frame immediately; no partial res update.

Configuration
REQ-024 Macro A2D_RES_INV_EN:
- Defined: res = ~shift register[11:0], so the IR sensors read larger for darker line.
- Undefined: res = shift register[11:0] unmodified.
- Nothing else differs between the two builds.

Verification
REQ-025 Reset:
- Hold rst_n=0 for 3 clk -> a2d_SS_n=1, SCLK=1, cnv_cmplt=0, res=0.
- Release -> all stay idle with no SCLK toggling for 200 clk.
REQ-026 Single conversion:
- strt_cnv pulse, chnnl=3'd5, ADC model returns 12'hA5C -> exactly 2 SS_n low windows of 16 SCLK each.
- MOSI bits [13:11] = 3'b101 in both frames.
- cnv_cmplt rises at 1030-1110 clk.
- res = 12'hA5C (macro undefined) or 12'h5A3 (macro defined).
REQ-027 SCLK timing: period exactly 32 clk, 16 high / 16 low; MISO sampled only on rising edges.
REQ-028 Busy request: a second strt_cnv with chnnl=3'd2 issued 300 clk into frame 1 -> ignored; the address stays 3'b101 and exactly one cnv_cmplt.
REQ-029 Back-to-back channels:
- Conversions on channels 0..7 in sequence, with the model returning 12'h100*ch + 12'h0FF.
- Each res matches; cnv_cmplt stays high until the next strt_cnv, then clears in the same clk.
REQ-030 Mid-frame reset: assert rst_n=0 during frame 2 -> SS_n=1 and SCLK=1 immediately, res unchanged at 0, no cnv_cmplt after release.
